sop_sweep_checker: RTL
======================

Name: sop_sweep_checker

Overview:
Parametrised on-board exhaustive tester for pair-wise sum-of-products logic y = OR_i (x_hi_i & ~x_lo_i). The four-input instance is y = AB' + CD'. It drives every input combination to an external combinational DUT and compares each response against an internal reference model. It reports pass/fail, an error count and the first failing vector. Supports free-run and single-step (button) sweeps for FPGA lab boards.

Parameters:
NUM_PAIRS, 2, number of (hi,lo) input pairs; legal 1..4; N_IN = 2*NUM_PAIRS
RESP_LAT, 0, cycles from a vector first appearing on stim to resp being sampled for it; legal 0..7

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin sweep; accepted only in IDLE or DONE
abort  input  1  return to IDLE from any state; wins over start
step_mode  input  1  0 = advance every cycle, 1 = advance only on step; sampled at start
step  input  1  single-cycle advance pulse, used when step_mode latched 1
resp  input  1  DUT output
stim  output  N_IN  registered test vector; stim[2i+1] = hi_i, stim[2i] = lo_i (a = stim[3], d = stim[0])
busy  output  1  high in SWEEP and DRAIN
done  output  1  high in DONE
pass  output  1  valid when done; 1 iff err_count == 0
err_count  output  N_IN+1  number of mismatching vectors; cannot overflow
first_fail  output  N_IN  index of first mismatching vector
fail_valid  output  1  first_fail holds a captured index

Behaviour:
- Reset (rst_n = 0 at a clk edge): state IDLE. All outputs are 0: stim, busy, done, pass, err_count, first_fail, fail_valid. Tag pipeline is cleared.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE or DONE with start = 1 and abort = 0 at edge T:
  - SWEEP from T+1, stim = 0.
  - err_count, fail_valid, first_fail, pass and done are cleared.
  - step_mode is latched.
- SWEEP advance condition:
  - free-run: every cycle.
  - step mode: a cycle with step = 1.
  - On advance, stim increments.
  - On advance with stim = 2^N_IN - 1: go to DRAIN; stim holds its last value.
- Tag pipeline: one token {valid, index, expected} is issued in the first cycle each new vector is on stim. It emerges RESP_LAT cycles later. expected = reference SOP of the index.
- RESP_LAT = 0: resp is compared in the issue cycle. In step mode, vectors held longer than RESP_LAT cycles are still compared only once.
- Compare on an emerging valid token with resp != expected:
  - err_count is incremented.
  - If fail_valid = 0: first_fail = index and fail_valid = 1.
  - Results are visible on the next cycle.
- DRAIN: lasts exactly RESP_LAT cycles (zero cycles means go directly to DONE). Then DONE, done = 1, pass = (err_count == 0).
- Free-run timing: start accepted at edge T gives done = 1 at cycle T + 2^N_IN + RESP_LAT + 1. busy is high for the cycles in between.
- DONE holds the results and stim until start or abort.
- start while busy is ignored.
- step pulses in free-run mode, or outside SWEEP, are ignored.
- abort in any state:
  - next cycle IDLE; stim = 0, busy = 0, done = 0, pass = 0; tag pipeline is flushed.
  - err_count, first_fail and fail_valid hold their values.
- abort and start in the same cycle: abort wins, state IDLE.
- Reset mid-sweep: identical to power-on reset. No partial results are retained.

Decomposition:
- Package sop_sweep_pkg:
  - function ref_sop(vector, NUM_PAIRS) returns OR_i (v[2i+1] & ~v[2i]).
  - state enum typedef {IDLE, SWEEP, DRAIN, DONE}.
  - localparams N_IN = 2*NUM_PAIRS and N_VEC = 2**N_IN as helper expressions.
- Sub-module sop_tag_delay: parametrised RESP_LAT-deep shift register of {valid, index, expected}. For RESP_LAT = 0 it is a pass-through. Synchronous flush input driven by abort/reset.

Test Plan:
- NUM_PAIRS=2, RESP_LAT=0, resp = (a&~b)|(c&~d) of stim; start at edge T -> stim 0..15 on cycles T+1..T+16, done at T+17, pass=1, err_count=0, fail_valid=0.
- Same config, resp tied 0 -> err_count=7 (vectors 2,6,8,9,10,11,14), first_fail=2, fail_valid=1, pass=0.
- Same config, resp = inverted reference -> err_count=16, first_fail=0, pass=0; then a second start -> counters cleared in the cycle after start, and a good DUT gives pass=1.
- RESP_LAT=2 with DUT output through a 2-flop delay -> pass=1, done at T+19; same bench with a 1-flop delay -> pass=0, err_count=8 (adjacent vectors compared), first_fail=1.
- step_mode=1: start, 3 step pulses separated by idle cycles -> stim=3, busy=1, err_count=0 with good DUT; assert abort together with start -> IDLE next cycle, stim=0, done=0, err_count held.
- Free-run sweep, pull rst_n low at stim=9 for one edge -> all outputs 0, state IDLE; start pulse during busy in a fresh sweep -> ignored, sweep length unchanged (16 cycles).

Source files
------------

// File: rtl/sop_sweep_pkg.sv
// Shared types and helpers for the sum-of-products sweep checker.
// Contents:
//   MAX_PAIRS / MAX_IN : widest supported instance (4 pairs, 8 inputs)
//   state_e            : sweep controller states
//   n_in / n_vec       : input width and vector count for a given pair count
//   ref_sop            : reference model y = OR_i (v[2i+1] & ~v[2i])
package sop_sweep_pkg;

    localparam int unsigned MAX_PAIRS = 4;
    localparam int unsigned MAX_IN    = 2 * MAX_PAIRS;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_e;

    function automatic int unsigned n_in(input int unsigned num_pairs);
        return 2 * num_pairs;
    endfunction

    function automatic int unsigned n_vec(input int unsigned num_pairs);
        return 32'd1 << (2 * num_pairs);
    endfunction

    // Pairs beyond num_pairs are ignored, so narrow vectors may be zero-extended.
    function automatic logic ref_sop(input logic [MAX_IN-1:0] vector,
                                     input int unsigned num_pairs);
        logic y;
        y = 1'b0;
        for (int unsigned i = 0; i < MAX_PAIRS; i++) begin
            if (i < num_pairs) begin
                y = y | (vector[2*i+1] & ~vector[2*i]);
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/sop_sweep_checker_if.sv
// Control/result bundle between a sweep checker and whoever operates it.
// master: operator side (drives start, abort, step_mode, step and the DUT response resp).
// slave : checker side (drives stim, busy, done, pass, err_count, first_fail, fail_valid).
interface sop_sweep_checker_if #(
    parameter int unsigned NUM_PAIRS = 2
);
    localparam int unsigned N_IN = 2 * NUM_PAIRS;

    logic            start;
    logic            abort;
    logic            step_mode;
    logic            step;
    logic            resp;
    logic [N_IN-1:0] stim;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail;
    logic            fail_valid;

    modport master (
        output start, abort, step_mode, step, resp,
        input  stim, busy, done, pass, err_count, first_fail, fail_valid
    );

    modport slave (
        input  start, abort, step_mode, step, resp,
        output stim, busy, done, pass, err_count, first_fail, fail_valid
    );

endinterface

// File: rtl/sop_tag_delay.sv
// Delay line for {valid, index, expected} tokens so each expected value lines up with the
// DUT response for its vector.
// Ports:
//   clk          : clock, rising edge
//   flush        : synchronous clear of every stage
//   in_valid/in_index/in_expected    : token entering this cycle
//   out_valid/out_index/out_expected : token issued DEPTH cycles earlier
// DEPTH = 0 is a combinational pass-through.
module sop_tag_delay #(
    parameter int unsigned DEPTH = 0,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_index,
    input  logic             in_expected,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic             out_expected
);

    if (DEPTH == 0) begin : g_pass
        logic unused_pass;
        assign unused_pass  = ^{clk, flush};
        assign out_valid    = in_valid;
        assign out_index    = in_index;
        assign out_expected = in_expected;
    end else begin : g_shift
        logic [DEPTH-1:0] valid_q;
        logic [DEPTH-1:0] exp_q;
        logic [IDX_W-1:0] index_q [DEPTH];

        always_ff @(posedge clk) begin
            if (flush) begin
                valid_q <= '0;
                exp_q   <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    index_q[i] <= '0;
                end
            end else begin
                valid_q[0] <= in_valid;
                exp_q[0]   <= in_expected;
                index_q[0] <= in_index;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    exp_q[i]   <= exp_q[i-1];
                    index_q[i] <= index_q[i-1];
                end
            end
        end

        assign out_valid    = valid_q[DEPTH-1];
        assign out_index    = index_q[DEPTH-1];
        assign out_expected = exp_q[DEPTH-1];
    end

endmodule

// File: rtl/sop_sweep_checker.sv
// Exhaustive on-board tester for y = OR_i (hi_i & ~lo_i). Walks stim through every input
// combination, compares the external DUT response against the reference model RESP_LAT
// cycles later, and reports pass/fail, the mismatch count and the first failing vector.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of sop_sweep_checker_if (start/abort/step_mode/step/resp in,
//           stim/busy/done/pass/err_count/first_fail/fail_valid out)
module sop_sweep_checker
    import sop_sweep_pkg::*;
#(
    parameter int unsigned NUM_PAIRS = 2,
    parameter int unsigned RESP_LAT  = 0
) (
    input logic               clk,
    input logic               rst_n,
    sop_sweep_checker_if.slave bus
);

    localparam int unsigned N_IN  = n_in(NUM_PAIRS);
    localparam int unsigned N_VEC = n_vec(NUM_PAIRS);
    localparam int unsigned DCW   = (RESP_LAT < 1) ? 1 : $clog2(RESP_LAT + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(RESP_LAT - 1);
    localparam logic [N_IN-1:0] STIM_LAST = N_IN'(N_VEC - 1);

    state_e          state_q, state_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic            mode_q, mode_d;
    logic            new_q, new_d;   // first cycle a vector is on stim
    logic [DCW-1:0]  drain_q, drain_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            fv_q, fv_d;
    logic            pass_q, pass_d;

    logic              issue_valid;
    logic              issue_expected;
    logic [MAX_IN-1:0] stim_ext;
    logic              tag_valid;
    logic [N_IN-1:0]   tag_index;
    logic              tag_expected;
    logic              mismatch;
    logic              advance;
    logic              flush;

    assign stim_ext       = MAX_IN'(stim_q);
    assign issue_valid    = (state_q == SWEEP) && new_q;
    assign issue_expected = ref_sop(stim_ext, NUM_PAIRS);
    assign flush          = !rst_n || bus.abort;

    sop_tag_delay #(
        .DEPTH (RESP_LAT),
        .IDX_W (N_IN)
    ) u_tag_delay (
        .clk          (clk),
        .flush        (flush),
        .in_valid     (issue_valid),
        .in_index     (stim_q),
        .in_expected  (issue_expected),
        .out_valid    (tag_valid),
        .out_index    (tag_index),
        .out_expected (tag_expected)
    );

    assign mismatch = tag_valid && (bus.resp != tag_expected);
    assign advance  = (state_q == SWEEP) && (!mode_q || bus.step);

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        mode_d  = mode_q;
        new_d   = 1'b0;
        drain_d = drain_q;
        err_d   = err_q;
        ff_d    = ff_q;
        fv_d    = fv_q;
        pass_d  = pass_q;

        // Tokens keep emerging during DRAIN, so comparison is independent of state.
        if (mismatch) begin
            err_d = err_q + 1'b1;
            if (!fv_q) begin
                ff_d = tag_index;
                fv_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = SWEEP;
                    stim_d  = '0;
                    mode_d  = bus.step_mode;
                    new_d   = 1'b1;
                    err_d   = '0;
                    ff_d    = '0;
                    fv_d    = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            SWEEP: begin
                if (advance) begin
                    if (stim_q == STIM_LAST) begin
                        drain_d = '0;
                        if (RESP_LAT == 0) begin
                            state_d = DONE;
                            pass_d  = (err_d == '0);
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        stim_d = stim_q + 1'b1;
                        new_d  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: ;
        endcase

        // Abort beats start and any in-flight comparison; results are left as they were.
        if (bus.abort) begin
            state_d = IDLE;
            stim_d  = '0;
            new_d   = 1'b0;
            drain_d = '0;
            pass_d  = 1'b0;
            err_d   = err_q;
            ff_d    = ff_q;
            fv_d    = fv_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stim_q  <= '0;
            mode_q  <= 1'b0;
            new_q   <= 1'b0;
            drain_q <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            mode_q  <= mode_d;
            new_q   <= new_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.stim       = stim_q;
    assign bus.busy       = (state_q == SWEEP) || (state_q == DRAIN);
    assign bus.done       = (state_q == DONE);
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = ff_q;
    assign bus.fail_valid = fv_q;

endmodule
